neopix_frame_arbiter: RTL and testbench

NEOPIX_FRAME_ARBITER -- requirements
Module: neopix_frame_arbiter

---
 rtl/neopix_frame_arbiter_if.sv | 45 ++++
 rtl/neopix_frame_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_neopix_frame_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neopix_frame_arbiter_if.sv
// Frame-buffer read port and byte handshake to the shared NeoPixel bit encoder.
// Latency: none, wires only.
// Backpressure: enc_ready from the encoder stalls the arbiter; rd_data has fixed 1-cycle latency.
interface neopix_frame_arbiter_if #(
    parameter int ADDR_W = 9
);
    // frame-buffer read request / return
    logic              rd_en;
    logic              rd_chan;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    // byte stream to the bit encoder
    logic [7:0]        enc_data;
    logic              enc_valid;
    logic              enc_ready;
    logic              enc_busy;
    logic              enc_sel;

    // arbiter side
    modport master (
        output rd_en,
        output rd_chan,
        output rd_addr,
        input  rd_data,
        output enc_data,
        output enc_valid,
        output enc_sel,
        input  enc_ready,
        input  enc_busy
    );

    // buffer + encoder side
    modport slave (
        input  rd_en,
        input  rd_chan,
        input  rd_addr,
        output rd_data,
        input  enc_data,
        input  enc_valid,
        input  enc_sel,
        output enc_ready,
        output enc_busy
    );
endinterface

// File: rtl/neopix_frame_arbiter.sv
// Arbitrates two NeoPixel frame buffers onto one bit encoder, one whole frame at a time, then holds the latch gap.
// Latency: encoder handshake to next enc_valid is 3 cycles (fetch, buffer read, register); req to grant is 1 cycle.
// Backpressure: enc_ready low holds enc_data/enc_valid stable; enc_busy high holds the latch gap off. Macro NEOPIX_ARB_STRICT_PRIO_EN selects fixed priority.
module neopix_frame_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] len0,
    input  logic [ADDR_W-1:0] len1,
    neopix_frame_arbiter_if.master bus,
    output logic              busy,
    output logic [1:0]        done
);

    // latch counter only needs to reach LATCH_CYCLES-1
    localparam int              CNT_W    = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        FETCH,
        WAIT,
        SEND,
        DRAIN,
        LATCH
    } state_t;

    state_t            state_q,     state_d;
    logic [1:0]        pending_q,   pending_d;
    logic              last_q,      last_d;
    logic              chan_q,      chan_d;
    logic [ADDR_W-1:0] len_q,       len_d;
    logic [ADDR_W-1:0] index_q,     index_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [7:0]        enc_data_q,  enc_data_d;
    logic              enc_valid_q, enc_valid_d;
    logic [1:0]        done_q,      done_d;

    logic [1:0]        pend_eff;
    logic              grant_chan;
    logic [ADDR_W-1:0] len_sel;
    logic [ADDR_W-1:0] index_inc;

    // a req arriving while idle is granted in the same cycle it is seen
    assign pend_eff  = pending_q | req;
    assign len_sel   = chan_q ? len1 : len0;
    assign index_inc = index_q + 1'b1;

    // pick the channel to serve next among the effective pending set
    always_comb begin
        grant_chan = 1'b0;
`ifdef NEOPIX_ARB_STRICT_PRIO_EN
        // channel 0 always wins a tie
        grant_chan = ~pend_eff[0];
`else
        // on a tie, serve the channel that was not served last
        if (&pend_eff) begin
            grant_chan = ~last_q;
        end else begin
            grant_chan = ~pend_eff[0];
        end
`endif
    end

    // frame sequencing: next state, datapath updates and done pulses
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q | req;
        last_d      = last_q;
        chan_d      = chan_q;
        len_d       = len_q;
        index_d     = index_q;
        cnt_d       = cnt_q;
        enc_data_d  = enc_data_q;
        enc_valid_d = enc_valid_q;
        done_d      = 2'b00;

        case (state_q)
            IDLE: begin
                if (|pend_eff) begin
                    // chan (and so enc_sel) is fixed from here to the end of LATCH
                    chan_d                = grant_chan;
                    last_d                = grant_chan;
                    pending_d[grant_chan] = 1'b0;
                    state_d               = GRANT;
                end
            end

            GRANT: begin
                len_d   = len_sel;
                index_d = '0;
                if (len_sel == '0) begin
                    // empty frame: report completion without touching the line
                    done_d[chan_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                // rd_en is decoded from this state; the byte returns next cycle
                state_d = WAIT;
            end

            WAIT: begin
                enc_data_d  = bus.rd_data;
                enc_valid_d = 1'b1;
                state_d     = SEND;
            end

            SEND: begin
                if (enc_valid_q && bus.enc_ready) begin
                    enc_valid_d = 1'b0;
                    index_d     = index_inc;
                    // index never exceeds len, so the increment cannot wrap
                    state_d     = (index_inc < len_q) ? FETCH : DRAIN;
                end
            end

            DRAIN: begin
                // last byte accepted; wait for its bits to leave the encoder
                if (!bus.enc_busy) begin
                    cnt_d   = '0;
                    state_d = LATCH;
                end
            end

            LATCH: begin
                if (cnt_q == CNT_LAST) begin
                    done_d[chan_q] = 1'b1;
                    state_d        = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and datapath registers; reset abandons any frame silently
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 2'b00;
            last_q      <= 1'b1;
            chan_q      <= 1'b0;
            len_q       <= '0;
            index_q     <= '0;
            cnt_q       <= '0;
            enc_data_q  <= 8'h00;
            enc_valid_q <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            last_q      <= last_d;
            chan_q      <= chan_d;
            len_q       <= len_d;
            index_q     <= index_d;
            cnt_q       <= cnt_d;
            enc_data_q  <= enc_data_d;
            enc_valid_q <= enc_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_en     = (state_q == FETCH);
    assign bus.rd_chan   = chan_q;
    assign bus.rd_addr   = index_q;
    assign bus.enc_data  = enc_data_q;
    assign bus.enc_valid = enc_valid_q;
    assign bus.enc_sel   = chan_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;

endmodule

// File: tb/tb_neopix_frame_arbiter.sv
// Directed bench for neopix_frame_arbiter: buffer model with 1-cycle read latency, encoder handshake driven by hand.
// Latency: expected cycle distances are derived from the frame timing (3-cycle byte loop, DRAIN, LATCH_CYCLES gap).
// Backpressure: enc_ready and enc_busy are held low/high in places to exercise stalls.
module tb_neopix_frame_arbiter;

    localparam int ADDR_W = 9;
    localparam int LATCH  = 2500;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [ADDR_W-1:0] len0;
    logic [ADDR_W-1:0] len1;
    logic              busy;
    logic [1:0]        done;

    neopix_frame_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

    neopix_frame_arbiter #(
        .ADDR_W       (ADDR_W),
        .LATCH_CYCLES (LATCH)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .req      (req),
        .len0     (len0),
        .len1     (len1),
        .bus      (bus),
        .busy     (busy),
        .done     (done)
    );

    always #10 clk = ~clk;

    // frame buffers, read data valid the cycle after rd_en, garbage otherwise
    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= bus.rd_chan ? mem1[bus.rd_addr] : mem0[bus.rd_addr];
        else           bus.rd_data <= 8'hEE;
    end

    // observation of the DUT outputs, cycle index = value of cyc after the edge
    int   cyc       = 0;
    int   last_hs   = 0;
    int   rd_cnt    = 0;
    int   done_cnt  = 0;
    int   valid_cnt = 0;
    int   rd_b2b    = 0;
    logic prev_rd    = 1'b0;
    logic prev_valid = 1'b0;
    logic [8:0]        hs_q   [$];
    int                gap_q  [$];
    logic [ADDR_W-1:0] addr_q [$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.enc_valid && bus.enc_ready) begin
            hs_q.push_back({bus.enc_sel, bus.enc_data});
            last_hs <= cyc;
        end
        if (bus.enc_valid && !prev_valid) gap_q.push_back(cyc - last_hs);
        if (bus.rd_en) begin
            rd_cnt <= rd_cnt + 1;
            addr_q.push_back(bus.rd_addr);
        end
        if (bus.rd_en && prev_rd) rd_b2b <= rd_b2b + 1;
        if (done != 2'b00)        done_cnt <= done_cnt + 1;
        if (bus.enc_valid)        valid_cnt <= valid_cnt + 1;
        prev_rd    <= bus.rd_en;
        prev_valid <= bus.enc_valid;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_req(input logic [1:0] r);
        req = r;
        @(negedge clk);
        req = 2'b00;
    endtask

    // returns the first nonzero done value and its cycle, or 0 / -1 on timeout
    task automatic wait_done(input int budget, output logic [1:0] d, output int at);
        d  = 2'b00;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                d  = done;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_hs(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (hs_q.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] d, d1, d2, d3;
        int at, at1, n, snap, snap2, bad;

        reset         = 1'b1;
        req           = 2'b00;
        len0          = '0;
        len1          = '0;
        bus.enc_ready = 1'b1;
        bus.enc_busy  = 1'b0;
        for (int i = 0; i < 512; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // reset state
        check("rst_busy",      32'(busy), 0);
        check("rst_enc_valid", 32'(bus.enc_valid), 0);
        check("rst_rd_en",     32'(bus.rd_en), 0);
        check("rst_done",      32'(done), 0);
        check("rst_enc_sel",   32'(bus.enc_sel), 0);
        check("rst_enc_data",  32'(bus.enc_data), 0);
        @(negedge clk);
        check("idle_no_req_busy", 32'(busy), 0);

        // single 3-byte frame on channel 0
        hs_q.delete();
        gap_q.delete();
        snap    = rd_cnt;
        mem0[0] = 8'hAA;
        mem0[1] = 8'h55;
        mem0[2] = 8'h00;
        len0    = 9'd3;
        pulse_req(2'b01);
        wait_done(3000, d, at);
        check("f1_done",   32'(d), 'b01);
        check("f1_nbytes", 32'(hs_q.size()), 3);
        check("f1_b0",     32'(hs_q[0]), 'h0AA);
        check("f1_b1",     32'(hs_q[1]), 'h055);
        check("f1_b2",     32'(hs_q[2]), 'h000);
        check("f1_gap1",   32'(gap_q[1]), 3);
        check("f1_gap2",   32'(gap_q[2]), 3);
        check("f1_reads",  32'(rd_cnt - snap), 3);
        // 1 DRAIN cycle + LATCH cycles, done registered on exit
        check("f1_latch",  32'(at - last_hs), 1 + LATCH + 1);
        @(negedge clk);
        check("f1_done_once", 32'(done), 0);
        check("f1_idle",      32'(busy), 0);

        // simultaneous requests, both 2-byte frames back to back
        do_reset();
        hs_q.delete();
        mem0[0] = 8'h11;
        mem0[1] = 8'h22;
        mem1[0] = 8'h33;
        mem1[1] = 8'h44;
        len0    = 9'd2;
        len1    = 9'd2;
        pulse_req(2'b11);
        wait_done(3000, d1, at1);
        wait_done(3000, d2, at);
        check("rr_done_a", 32'(d1), 'b01);
        check("rr_done_b", 32'(d2), 'b10);
        check("rr_nbytes", 32'(hs_q.size()), 4);
        check("rr_b0",     32'(hs_q[0]), 'h011);
        check("rr_b1",     32'(hs_q[1]), 'h022);
        check("rr_b2",     32'(hs_q[2]), 'h133);
        check("rr_b3",     32'(hs_q[3]), 'h144);
        // grant, 2x(fetch,wait,send), drain, latch, done register
        check("rr_spacing", 32'(at - at1), 1 + 6 + 1 + LATCH + 1);

        // encoder stalls, then holds enc_busy during drain
        hs_q.delete();
        mem0[0]       = 8'h5A;
        mem0[1]       = 8'hA5;
        mem0[2]       = 8'hC3;
        len0          = 9'd3;
        bus.enc_ready = 1'b0;
        bus.enc_busy  = 1'b1;
        pulse_req(2'b01);
        for (int i = 0; i < 20; i++) begin
            if (bus.enc_valid) break;
            @(negedge clk);
        end
        check("stall_valid", 32'(bus.enc_valid), 1);
        check("stall_data",  32'(bus.enc_data), 'h5A);
        snap = rd_cnt;
        bad  = 0;
        repeat (10) begin
            @(negedge clk);
            if (!(bus.enc_valid === 1'b1 && bus.enc_data === 8'h5A)) bad++;
        end
        check("stall_stable",  32'(bad), 0);
        check("stall_no_read", 32'(rd_cnt - snap), 0);
        check("stall_no_hs",   32'(hs_q.size()), 0);
        bus.enc_ready = 1'b1;
        wait_hs(3, 50);
        check("stall_nbytes", 32'(hs_q.size()), 3);
        check("stall_b1",     32'(hs_q[1]), 'h0A5);
        check("stall_b2",     32'(hs_q[2]), 'h0C3);
        snap2 = done_cnt;
        repeat (20) @(negedge clk);
        check("drain_busy",    32'(busy), 1);
        check("drain_no_done", 32'(done_cnt - snap2), 0);
        bus.enc_busy = 1'b0;
        n = cyc;
        wait_done(3000, d, at);
        check("drain_done",  32'(d), 'b01);
        check("drain_latch", 32'(at - n), LATCH + 1);

        // empty frame on channel 1
        len1  = '0;
        snap  = rd_cnt;
        snap2 = valid_cnt;
        req   = 2'b10;
        n     = cyc;
        @(negedge clk);
        req = 2'b00;
        wait_done(2, d, at);
        check("empty_done",     32'(d), 'b10);
        check("empty_latency",  32'(at - n), 2);
        check("empty_no_read",  32'(rd_cnt - snap), 0);
        check("empty_no_valid", 32'(valid_cnt - snap2), 0);
        @(negedge clk);
        check("empty_idle",     32'(busy), 0);

        // reset in the middle of a 6-byte frame
        hs_q.delete();
        for (int i = 0; i < 6; i++) mem0[i] = 8'(i + 1);
        len0 = 9'd6;
        pulse_req(2'b01);
        wait_hs(2, 100);
        check("abort_reached_b2", 32'(hs_q.size()), 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_valid", 32'(bus.enc_valid), 0);
        check("abort_busy",  32'(busy), 0);
        check("abort_rd_en", 32'(bus.rd_en), 0);
        snap2 = done_cnt;
        repeat (LATCH + 100) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - snap2), 0);
        check("abort_stays_idle", 32'(busy), 0);
        hs_q.delete();
        addr_q.delete();
        pulse_req(2'b01);
        wait_done(4000, d, at);
        check("restart_done",   32'(d), 'b01);
        check("restart_addr0",  32'(addr_q[0]), 0);
        check("restart_nbytes", 32'(hs_q.size()), 6);
        check("restart_last",   32'(hs_q[5]), 'h006);

        // maximum length frame, index must not wrap
        hs_q.delete();
        addr_q.delete();
        for (int i = 0; i < 512; i++) mem0[i] = 8'(i);
        len0 = 9'h1FF;
        snap = rd_cnt;
        pulse_req(2'b01);
        wait_done(6000, d, at);
        check("max_done",      32'(d), 'b01);
        check("max_nbytes",    32'(hs_q.size()), 511);
        check("max_last_byte", 32'(hs_q[510]), 'h0FE);
        check("max_last_addr", 32'(addr_q[510]), 510);
        check("max_reads",     32'(rd_cnt - snap), 511);

        // repeated simultaneous requests after each done
        do_reset();
        hs_q.delete();
        len0    = 9'd1;
        len1    = 9'd1;
        mem0[0] = 8'hC0;
        mem1[0] = 8'hC1;
        pulse_req(2'b11);
        wait_done(3000, d1, at);
        pulse_req(2'b11);
        wait_done(3000, d2, at);
        pulse_req(2'b11);
        wait_done(3000, d3, at);
        check("arb_grant1", 32'(d1), 'b01);
`ifdef NEOPIX_ARB_STRICT_PRIO_EN
        check("arb_grant2", 32'(d2), 'b01);
        check("arb_sel2",   32'(hs_q[1]), 'h0C0);
`else
        check("arb_grant2", 32'(d2), 'b10);
        check("arb_sel2",   32'(hs_q[1]), 'h1C1);
`endif
        check("arb_grant3", 32'(d3), 'b01);

        check("rd_en_single_cycle", 32'(rd_b2b), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
